// File: rtl/note_history_buffer_pkg.sv
// Shared widths and types for the note history path.
// NOTE_W/SONG_W match note_display; HIST_LEN is the number of displayed notes.
package note_history_buffer_pkg;

  localparam int unsigned NOTE_W   = 6;
  localparam int unsigned SONG_W   = 2;
  localparam int unsigned HIST_LEN = 3;

  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [SONG_W-1:0] song_t;

  localparam note_t NOTE_REST = '0;

  // A rest is only queued when rest skipping is disabled.
  function automatic logic is_queueable(input note_t n, input logic skip_rests);
    return !skip_rests || (n != NOTE_REST);
  endfunction

endpackage

// File: rtl/note_history_buffer_if.sv
// Bus between the song player / video timing side and the note history buffer.
//   master : player side, drives note_in/note_valid/song_in/vsync, reads results
//   slave  : note_history_buffer, drives note_one..three, song, frame_tick,
//            overflow and pending
interface note_history_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  import note_history_buffer_pkg::*;

  note_t                       note_in;
  logic                        note_valid;
  song_t                       song_in;
  logic                        vsync;
  note_t                       note_one;
  note_t                       note_two;
  note_t                       note_three;
  song_t                       song;
  logic                        frame_tick;
  logic                        overflow;
  logic [$clog2(FIFO_DEPTH):0] pending;

  modport master (
    output note_in, note_valid, song_in, vsync,
    input  note_one, note_two, note_three, song, frame_tick, overflow, pending
  );

  modport slave (
    input  note_in, note_valid, song_in, vsync,
    output note_one, note_two, note_three, song, frame_tick, overflow, pending
  );

endinterface

// File: rtl/note_history_buffer_fifo.sv
// note_fifo: synchronous FIFO with separate occupancy counter.
//   clear : flush (wins over push/pop)
//   push  : write din at tail; ignored when full unless a pop happens too
//   pop   : advance head; ignored when empty (judged on pre-push state)
//   dout  : current head, full/empty/count from registered occupancy
// DEPTH must be a power of two, at least 2.
module note_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/note_history_buffer.sv
// note_history_buffer: queues player note codes and shifts at most one per
// video frame into a three-deep display history for note_display.
//   clk, reset : system clock, synchronous active-high reset
//   bus.slave  : note_in/note_valid/song_in/vsync in;
//                note_one/two/three, song, frame_tick, overflow, pending out
// A frame boundary is the cycle where the registered vsync is 1 and vsync is 0.
// A song change flushes queue and history and clears overflow.
module note_history_buffer
  import note_history_buffer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          SKIP_RESTS = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  note_history_if.slave bus
);

  logic  vsync_q, vsync_d;
  song_t song_in_q, song_in_d;
  song_t song_q, song_d;
  logic  frame_tick_q, frame_tick_d;
  logic  overflow_q, overflow_d;
  note_t hist_q [HIST_LEN];
  note_t hist_d [HIST_LEN];

  logic  boundary, song_change, push_req, pop_fire, drop;
  note_t fifo_dout;
  logic  fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign boundary    = vsync_q && !bus.vsync;
  assign song_change = (bus.song_in != song_in_q);
  assign push_req    = bus.note_valid && is_queueable(bus.note_in, SKIP_RESTS) && !song_change;
  // Emptiness is the pre-push state, so a same-cycle push into an empty queue is not popped.
  assign pop_fire    = boundary && !fifo_empty && !song_change;
  assign drop        = push_req && fifo_full && !pop_fire;

  note_fifo #(
    .WIDTH (NOTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (song_change),
    .push  (push_req),
    .pop   (pop_fire),
    .din   (bus.note_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    vsync_d      = bus.vsync;
    song_in_d    = bus.song_in;
    frame_tick_d = boundary;
    song_d       = boundary ? bus.song_in : song_q;
    overflow_d   = overflow_q;
    hist_d       = hist_q;
    if (song_change) begin
      hist_d     = '{default: '0};
      overflow_d = 1'b0;
    end else begin
      if (pop_fire) begin
        for (int unsigned i = HIST_LEN - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
        hist_d[0] = fifo_dout;
      end
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q      <= 1'b1;
      song_in_q    <= '0;
      song_q       <= '0;
      frame_tick_q <= 1'b0;
      overflow_q   <= 1'b0;
      hist_q       <= '{default: '0};
    end else begin
      vsync_q      <= vsync_d;
      song_in_q    <= song_in_d;
      song_q       <= song_d;
      frame_tick_q <= frame_tick_d;
      overflow_q   <= overflow_d;
      hist_q       <= hist_d;
    end
  end

  assign bus.note_one   = hist_q[0];
  assign bus.note_two   = hist_q[1];
  assign bus.note_three = hist_q[2];
  assign bus.song       = song_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.overflow   = overflow_q;
  assign bus.pending    = fifo_count;

endmodule

// File: tb/tb_note_history_buffer.sv
// Scoreboard bench for note_history_buffer: each frame stimulus pushes the
// expected post-frame state; a monitor compares it on every frame_tick.
module tb_note_history_buffer;
  import note_history_buffer_pkg::*;

  typedef struct packed {
    note_t      n1;
    note_t      n2;
    note_t      n3;
    song_t      song;
    logic [2:0] pend;
    logic       ovf;
  } exp_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   ticks    = 0;
  exp_t sb_q[$];

  note_history_if #(.FIFO_DEPTH(4)) bif();

  note_history_buffer #(
    .FIFO_DEPTH (4),
    .SKIP_RESTS (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs only change on posedge, so the negedge is a safe sample point.
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (!reset && bif.frame_tick) begin
      ticks++;
      got = '{n1: bif.note_one, n2: bif.note_two, n3: bif.note_three,
              song: bif.song, pend: bif.pending, ovf: bif.overflow};
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tick got n=(%0d,%0d,%0d) song=%0d pend=%0d ovf=%0d expected no tick",
                 got.n1, got.n2, got.n3, got.song, got.pend, got.ovf);
      end else begin
        e = sb_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL frame got n=(%0d,%0d,%0d) song=%0d pend=%0d ovf=%0d exp n=(%0d,%0d,%0d) song=%0d pend=%0d ovf=%0d",
                   got.n1, got.n2, got.n3, got.song, got.pend, got.ovf,
                   e.n1, e.n2, e.n3, e.song, e.pend, e.ovf);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_n1"}, int'(bif.note_one), 0);
    chk({name, "_n2"}, int'(bif.note_two), 0);
    chk({name, "_n3"}, int'(bif.note_three), 0);
    chk({name, "_pend"}, int'(bif.pending), 0);
    chk({name, "_ovf"}, int'(bif.overflow), 0);
    chk({name, "_tick"}, int'(bif.frame_tick), 0);
  endtask

  task automatic push(input note_t n);
    bif.note_in    = n;
    bif.note_valid = 1'b1;
    @(negedge clk);
    bif.note_valid = 1'b0;
  endtask

  task automatic frame(input exp_t e);
    sb_q.push_back(e);
    bif.vsync = 1'b0;
    @(negedge clk);
    bif.vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_push(input note_t n, input exp_t e);
    sb_q.push_back(e);
    bif.note_in    = n;
    bif.note_valid = 1'b1;
    bif.vsync      = 1'b0;
    @(negedge clk);
    bif.note_valid = 1'b0;
    bif.vsync      = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic exp_t mk(input int n1, input int n2, input int n3,
                              input int s, input int p, input int o);
    return '{n1: note_t'(n1), n2: note_t'(n2), n3: note_t'(n3),
             song: song_t'(s), pend: 3'(p), ovf: 1'(o)};
  endfunction

  initial begin
    reset          = 1'b1;
    bif.note_in    = '0;
    bif.note_valid = 1'b0;
    bif.song_in    = '0;
    bif.vsync      = 1'b1;
    @(negedge clk);
    do_reset(2);
    chk_all_zero("reset");
    chk("reset_song", int'(bif.song), 0);

    repeat (100) @(negedge clk);
    chk("idle_ticks", ticks, 0);

    // Basic shift
    push(2); push(4); push(9);
    chk("shift_pend", int'(bif.pending), 3);
    frame(mk(2, 0, 0, 0, 2, 0));
    frame(mk(4, 2, 0, 0, 1, 0));
    frame(mk(9, 4, 2, 0, 0, 0));

    // Rests are not queued
    push(0); push(19); push(0);
    chk("rest_pend", int'(bif.pending), 1);
    frame(mk(19, 9, 4, 0, 0, 0));

    // Overflow: fifth note dropped; extra frame on empty queue keeps history
    push(46); push(27); push(33); push(14); push(22);
    chk("ovf_pend", int'(bif.pending), 4);
    chk("ovf_flag", int'(bif.overflow), 1);
    frame(mk(46, 19, 9, 0, 3, 1));
    frame(mk(27, 46, 19, 0, 2, 1));
    frame(mk(33, 27, 46, 0, 1, 1));
    frame(mk(14, 33, 27, 0, 0, 1));
    frame(mk(14, 33, 27, 0, 0, 1));

    // Reset mid-frame with three pending
    push(5); push(6); push(7);
    chk("mid_pend", int'(bif.pending), 3);
    bif.vsync = 1'b0;
    @(negedge clk);
    bif.vsync = 1'b1;
    sb_q.push_back(mk(5, 14, 33, 0, 2, 1));
    @(negedge clk);
    do_reset(1);
    chk_all_zero("midreset");
    frame(mk(0, 0, 0, 0, 0, 0));

    // Push coincident with pop on a full queue
    push(11); push(12); push(13); push(14);
    chk("full_pend", int'(bif.pending), 4);
    frame_push(15, mk(11, 0, 0, 0, 4, 0));
    chk("coinc_ovf", int'(bif.overflow), 0);
    frame(mk(12, 11, 0, 0, 3, 0));
    frame(mk(13, 12, 11, 0, 2, 0));
    frame(mk(14, 13, 12, 0, 1, 0));
    frame(mk(15, 14, 13, 0, 0, 0));

    // Song change flushes everything and drops a coincident note
    do_reset(1);
    push(2); push(4); push(9);
    frame(mk(2, 0, 0, 0, 2, 0));
    frame(mk(4, 2, 0, 0, 1, 0));
    frame(mk(9, 4, 2, 0, 0, 0));
    push(1); push(3); push(5); push(7); push(8);
    chk("pre_song_pend", int'(bif.pending), 4);
    chk("pre_song_ovf", int'(bif.overflow), 1);
    bif.song_in    = 2'd1;
    bif.note_in    = 6'd40;
    bif.note_valid = 1'b1;
    @(negedge clk);
    bif.note_valid = 1'b0;
    chk_all_zero("songchg");
    chk("songchg_song", int'(bif.song), 0);
    repeat (3) @(negedge clk);
    chk("song_hold", int'(bif.song), 0);
    chk("post_song_pend", int'(bif.pending), 0);
    frame(mk(0, 0, 0, 1, 0, 0));

    repeat (4) @(negedge clk);
    chk("sb_leftover", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
